// File: rtl/gpu_task_dispatcher.sv
// rtl/gpu_task_dispatcher.sv - program buffer and burst dispatcher feeding gpu cores over a shared instruction bus
module gpu_task_dispatcher #(
  parameter int N_CORES  = 2,
  parameter int N_PROGS  = 4,
  parameter int PROG_LEN = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_we,
  input  logic [$clog2(N_PROGS)+3:0]   host_addr,
  input  logic [15:0]                  host_data,
  input  logic                         start,
  input  logic [$clog2(N_PROGS):0]     prog_count,
  output logic [15:0]                  instruction,
  output logic [N_CORES-1:0]           val_ins,
  input  logic [N_CORES-1:0]           rtr,
  input  logic [N_CORES-1:0]           ready,
  output logic [N_CORES-1:0]           cores_busy,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = $clog2(N_PROGS);
  localparam int SW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [PW:0] MAX_PROGS = (PW+1)'(N_PROGS);
  localparam logic [3:0]  LAST_WORD = 4'(PROG_LEN-1);

  typedef enum logic [1:0] {IDLE, PICK, SEND, DRAIN} state_t;

  state_t              state, state_nx;
  logic [15:0]         prog_mem [N_PROGS*PROG_LEN];
  logic [PW:0]         prog_ptr, prog_total, count_sat;
  logic [3:0]          word_ptr;
  logic [SW-1:0]       sel, pick;
  logic [N_CORES-1:0]  elig, val_nx, busy_set, cores_busy_nx;
  logic                any_elig, send_word, last_word, done_nx;

  assign count_sat = (prog_count > MAX_PROGS) ? MAX_PROGS : prog_count;
  assign elig      = rtr & ~cores_busy;
  assign any_elig  = |elig;
  assign send_word = (state == SEND) && rtr[sel];
  assign last_word = send_word && (word_ptr == LAST_WORD);

  // lowest-index idle core that is ready to receive
  always_comb begin
    pick = '0;
    for (int i = N_CORES-1; i >= 0; i--) begin
      if (elig[i]) pick = SW'(i);
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (count_sat != '0)) state_nx = PICK;
      PICK:    if (any_elig) state_nx = SEND;
      SEND:    if (last_word) state_nx = ((prog_ptr + 1'b1) < prog_total) ? PICK : DRAIN;
      DRAIN:   if (cores_busy == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs; a last-word set beats a same-cycle ready clear
  always_comb begin
    val_nx = '0;
    if (send_word) val_nx[sel] = 1'b1;
    busy_set = last_word ? val_nx : '0;
    cores_busy_nx = (cores_busy & ~ready) | busy_set;
    done_nx = ((state == IDLE) && start && (count_sat == '0)) ||
              ((state == DRAIN) && (cores_busy == '0));
  end

  // registered outputs and dispatch pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= '0;
      val_ins     <= '0;
      cores_busy  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prog_ptr    <= '0;
      prog_total  <= '0;
      word_ptr    <= '0;
      sel         <= '0;
    end else begin
      val_ins    <= val_nx;
      cores_busy <= cores_busy_nx;
      busy       <= (state_nx != IDLE);
      done       <= done_nx;
      if (state == IDLE && start) begin
        prog_total <= count_sat;
        prog_ptr   <= '0;
      end
      if (state == PICK && any_elig) begin
        sel      <= pick;
        word_ptr <= '0;
      end
      if (send_word) begin
        instruction <= prog_mem[{prog_ptr[PW-1:0], word_ptr}];
        word_ptr    <= word_ptr + 1'b1;
        if (last_word) prog_ptr <= prog_ptr + 1'b1;
      end
    end
  end

  // program buffer: host writes only land while idle
  always_ff @(posedge clk) begin
    if (host_we && state == IDLE) prog_mem[host_addr] <= host_data;
  end

endmodule

// File: tb/tb_gpu_task_dispatcher.sv
// tb/tb_gpu_task_dispatcher.sv - directed self-checking bench for gpu_task_dispatcher
module tb_gpu_task_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [15:0] host_data;
  logic        start;
  logic [2:0]  prog_count;
  logic [15:0] instruction;
  logic [1:0]  val_ins;
  logic [1:0]  rtr;
  logic [1:0]  ready;
  logic [1:0]  cores_busy;
  logic        busy;
  logic        done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  gpu_task_dispatcher #(.N_CORES(2), .N_PROGS(4), .PROG_LEN(16)) dut (
    .clk(clk), .reset(reset), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .start(start), .prog_count(prog_count),
    .instruction(instruction), .val_ins(val_ins), .rtr(rtr), .ready(ready),
    .cores_busy(cores_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p);
    for (int k = 0; k < 16; k++) begin
      host_we   = 1'b1;
      host_addr = 6'(p*16 + k);
      host_data = 16'(16'h1000 + p*16'h0100 + k);
      step();
    end
    host_we = 1'b0;
  endtask

  task automatic launch(input int cnt);
    start      = 1'b1;
    prog_count = 3'(cnt);
    step();
    start      = 1'b0;
  endtask

  // receive one burst; the bench plays the core and drops ready on the first word
  task automatic burst(input string tag, input int core, input logic [15:0] base,
                       input int first_exp, input int stall_at, input int stall_len,
                       input int gaps_exp);
    int n = 0, waitc = 0, gaps = 0, first = -1, hold = 0;
    while (n < 16 && waitc < 300) begin
      step();
      waitc++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) rtr[core] = 1'b1;
      end
      if (val_ins != 2'b00) begin
        if (first < 0) begin
          first = waitc;
          ready[core] = 1'b0;
        end
        check({tag, "_val"}, val_ins, 32'(1 << core));
        check({tag, "_word"}, instruction, base + 16'(n));
        n++;
        if (n == stall_at && stall_len > 0) begin
          rtr[core] = 1'b0;
          hold = stall_len;
        end
      end else if (first >= 0) begin
        gaps++;
      end
    end
    check({tag, "_count"}, n, 16);
    check({tag, "_gaps"}, gaps, gaps_exp);
    if (first_exp > 0) check({tag, "_latency"}, first, first_exp);
  endtask

  task automatic wait_done(input string tag);
    int waitc = 0;
    while (done !== 1'b1 && waitc < 100) begin
      step();
      waitc++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    step();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    reset = 1'b0; host_we = 1'b0; host_addr = '0; host_data = '0;
    start = 1'b0; prog_count = '0; rtr = 2'b00; ready = 2'b00;
    step();
    check("rst_val", val_ins, 0);
    check("rst_instr", instruction, 0);
    check("rst_cbusy", cores_busy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    step();
    load(0);
    load(1);
    load(2);

    // 1: single program to core 0
    rtr = 2'b11;
    launch(1);
    check("t1_busy", busy, 1);
    check("t1_val0", val_ins, 0);
    burst("t1", 0, 16'h1000, 2, 0, 0, 0);
    check("t1_cbusy", cores_busy, 2'b01);
    step();
    check("t1_drain", val_ins, 0);
    ready[0] = 1'b1;
    step();
    check("t1_clear", cores_busy, 2'b00);
    wait_done("t1");

    // 2: two programs across two cores, one gap cycle between bursts
    launch(2);
    burst("t2a", 0, 16'h1000, 2, 0, 0, 0);
    check("t2_cbusy_a", cores_busy, 2'b01);
    burst("t2b", 1, 16'h1100, 2, 0, 0, 0);
    check("t2_cbusy_b", cores_busy, 2'b11);
    ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t2_no_early_done", done, 0);
    check("t2_still_busy", busy, 1);
    check("t2_cbusy_c", cores_busy, 2'b10);
    ready[1] = 1'b1;
    wait_done("t2");

    // 3: three programs, both cores busy until ready[1] rises
    launch(3);
    burst("t3a", 0, 16'h1000, 2, 0, 0, 0);
    burst("t3b", 1, 16'h1100, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    check("t3_hold_val", val_ins, 0);
    check("t3_hold_busy", busy, 1);
    check("t3_hold_cbusy", cores_busy, 2'b11);
    ready[1] = 1'b1;
    burst("t3c", 1, 16'h1200, 3, 0, 0, 0);
    ready = 2'b11;
    wait_done("t3");

    // 4: rtr[0] low for 3 cycles at word 5
    launch(1);
    burst("t4", 0, 16'h1000, 2, 5, 3, 3);
    ready[0] = 1'b1;
    wait_done("t4");

    // 5: reset mid-burst, zero-length run, host write ignored while busy
    launch(1);
    begin
      int waitc = 0;
      while (!(val_ins == 2'b01 && instruction == 16'h1007) && waitc < 40) begin
        step();
        waitc++;
      end
      check("t5_reach_w7", instruction, 16'h1007);
    end
    #2 reset = 1'b0;
    #1;
    check("t5_rst_val", val_ins, 0);
    check("t5_rst_instr", instruction, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cbusy", cores_busy, 0);
    step();
    reset = 1'b1;
    step();
    launch(0);
    check("t5_zero_done", done, 1);
    check("t5_zero_val", val_ins, 0);
    check("t5_zero_busy", busy, 0);
    step();
    check("t5_zero_pulse", done, 0);
    rtr = 2'b00;
    launch(1);
    host_we = 1'b1; host_addr = 6'd3; host_data = 16'hdead;
    step();
    host_we = 1'b0;
    check("t5_pick_hold", val_ins, 0);
    rtr = 2'b11;
    burst("t5", 0, 16'h1000, 0, 0, 0, 0);
    ready[0] = 1'b1;
    wait_done("t5");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
